// File: rtl/top_sim.sv
// -----------------------------------------------------------------------------
// top_sim -- board-level simulation top.
//
// Divides the board clock, runs the cpu and memory blocks from the divided
// clock, feeds the switches into the CPU input port, drives the LEDs from the
// CPU output port and shows PC / SP as two-digit decimal numbers on four
// active-low 7-segment digits.
//
// Optional build macro: TOP_SIM_HEARTBEAT_EN
//   defined   : led[9] shows the divided CPU clock, led[8:0] = out[8:0]
//   undefined : led[9:0] = out[9:0]
//
// Contents of this file (in order):
//   top_sim_pkg : instruction opcodes shared by cpu and memory boot image
//   memory      : single-port RAM, combinational read, write on clk rise
//   cpu         : two-phase (fetch / execute) accumulator CPU, PC and SP
//   top_sim     : clock divider, integration, LED and 7-segment display
//
// top_sim ports:
//   clk   in   1   board clock
//   rst_n in   1   asynchronous reset, ACTIVE-HIGH despite the name
//   btn   in   3   push buttons, reserved and ignored
//   sw    in   9   switches, CPU input value (zero-extended)
//   led   out 10   CPU output low bits (see macro above for led[9])
//   hex   out 28   {SP tens, SP ones, PC tens, PC ones}, 7 bits each,
//                  segment order {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------

package top_sim_pkg;
    // Instruction word: opcode in the top nibble, operand address in the
    // low ADDR_WIDTH bits.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;  // acc = mem[a]
    localparam logic [3:0] OP_ST   = 4'h2;  // mem[a] = acc
    localparam logic [3:0] OP_IN   = 4'h3;  // acc = in
    localparam logic [3:0] OP_OUT  = 4'h4;  // out = acc
    localparam logic [3:0] OP_PUSH = 4'h5;  // mem[sp] = acc, sp--
    localparam logic [3:0] OP_POP  = 4'h6;  // sp++, acc = mem[sp]
    localparam logic [3:0] OP_JMP  = 4'h7;  // pc = a
endpackage

// -----------------------------------------------------------------------------
// memory -- clk, we, addr, data in; out = word at addr (combinational read).
// Power-up contents are the built-in boot image; FILE_NAME names the board
// image and is carried through unchanged. Contents survive reset.
// -----------------------------------------------------------------------------
module memory
    import top_sim_pkg::*;
#(
    parameter FILE_NAME  = "mem_init.hex",
    parameter ADDR_WIDTH = 6,
    parameter DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] image_t;

    function automatic logic [DATA_WIDTH-1:0] ins(input logic [3:0] op, input int a);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        w[DATA_WIDTH-1 -: 4] = op;
        w[ADDR_WIDTH-1:0]    = ADDR_WIDTH'(a);
        return w;
    endfunction

    // Boot program: show the word saved by the previous run, echo the
    // switches twice, save the last switch value, then jump through the top
    // of memory, push once and park in a tight loop.
    function automatic image_t boot_image();
        image_t img;
        img     = '0;
        img[0]  = ins(OP_JMP, 16);
        img[8]  = ins(OP_LD, 40);
        img[9]  = ins(OP_OUT, 0);
        img[10] = ins(OP_IN, 0);
        img[11] = ins(OP_OUT, 0);
        img[12] = ins(OP_IN, 0);
        img[13] = ins(OP_OUT, 0);
        img[14] = ins(OP_ST, 40);
        img[15] = ins(OP_JMP, 60);
        img[16] = ins(OP_JMP, 16);
        img[60] = ins(OP_JMP, 63);
        img[63] = ins(OP_PUSH, 0);
        return img;
    endfunction

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q = boot_image();
    logic [$bits(FILE_NAME)-1:0]      unused_name;

    assign unused_name = FILE_NAME;

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= data;
    end

    assign out = mem_q[addr];
endmodule

// -----------------------------------------------------------------------------
// cpu -- accumulator CPU, every instruction takes one fetch and one execute
// cycle of clk. Reset (active-low) gives PC=8, SP=all ones, out=0.
// Ports: clk, rst_n, in_i (input port), mem_in_i (memory read data),
//        out_o (output port), we_o/addr_o/data_o (memory), pc_o, sp_o.
// -----------------------------------------------------------------------------
module cpu
    import top_sim_pkg::*;
#(
    parameter ADDR_WIDTH = 6,
    parameter DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic [DATA_WIDTH-1:0] mem_in_i,
    output logic [DATA_WIDTH-1:0] out_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] sp_o
);
    typedef enum logic {S_FETCH, S_EXEC} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, sp_q, sp_d, arg_q, arg_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, out_q, out_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_WIDTH'(8);
            sp_q    <= '1;
            arg_q   <= '0;
            op_q    <= OP_NOP;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            arg_q   <= arg_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        arg_d   = arg_q;
        op_d    = op_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            S_FETCH: begin
                op_d    = mem_in_i[DATA_WIDTH-1 -: 4];
                arg_d   = mem_in_i[ADDR_WIDTH-1:0];
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = S_EXEC;
            end
            default: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_LD:   acc_d = mem_in_i;
                    OP_IN:   acc_d = in_i;
                    OP_OUT:  out_d = acc_q;
                    OP_PUSH: sp_d  = sp_q - ADDR_WIDTH'(1);
                    OP_POP: begin
                        sp_d  = sp_q + ADDR_WIDTH'(1);
                        acc_d = mem_in_i;
                    end
                    OP_JMP:  pc_d  = arg_q;
                    default: ;
                endcase
            end
        endcase
    end

    // Outputs: memory bus follows the current phase
    always_comb begin
        we_o   = 1'b0;
        addr_o = pc_q;
        data_o = acc_q;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_LD:   addr_o = arg_q;
                OP_ST: begin
                    addr_o = arg_q;
                    we_o   = 1'b1;
                end
                OP_PUSH: begin
                    addr_o = sp_q;
                    we_o   = 1'b1;
                end
                OP_POP:  addr_o = sp_q + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign out_o = out_q;
    assign pc_o  = pc_q;
    assign sp_o  = sp_q;
endmodule

// -----------------------------------------------------------------------------
// top_sim -- see file header for port summary.
// -----------------------------------------------------------------------------
module top_sim #(
    parameter DIVISOR    = 5,
    parameter FILE_NAME  = "mem_init.hex",
    parameter ADDR_WIDTH = 6,
    parameter DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  btn,
    input  logic [8:0]  sw,
    output logic [9:0]  led,
    output logic [27:0] hex
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic                  rst;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic                  cpu_clk_q, cpu_clk_d;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr, cpu_pc, cpu_sp;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata, cpu_in, cpu_out;
    logic [DATA_WIDTH-1:0] unused_out;
    logic [2:0]            unused_btn;
    logic [6:0]            pc_mod, sp_mod;
    logic [3:0]            pc_tens, pc_ones, sp_tens, sp_ones;

    // The reset port is active-high even though it is called rst_n.
    assign rst        = rst_n;
    assign unused_btn = btn;
    assign unused_out = cpu_out;

    // Divider: cpu_clk toggles each time the counter wraps, so its period is
    // 2*DIVISOR clk cycles and its first rise is DIVISOR edges after reset.
    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        cpu_clk_d = cpu_clk_q;
        if (div_cnt_q == CW'(DIVISOR - 1)) begin
            div_cnt_d = '0;
            cpu_clk_d = ~cpu_clk_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            cpu_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cpu_clk_q <= cpu_clk_d;
        end
    end

    assign cpu_in = {{(DATA_WIDTH-9){1'b0}}, sw};

    cpu #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cpu (
        .clk      (cpu_clk_q),
        .rst_n    (~rst),
        .in_i     (cpu_in),
        .mem_in_i (mem_rdata),
        .out_o    (cpu_out),
        .we_o     (mem_we),
        .addr_o   (mem_addr),
        .data_o   (mem_wdata),
        .pc_o     (cpu_pc),
        .sp_o     (cpu_sp)
    );

    memory #(
        .FILE_NAME  (FILE_NAME),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk  (cpu_clk_q),
        .we   (mem_we),
        .addr (mem_addr),
        .data (mem_wdata),
        .out  (mem_rdata)
    );

`ifdef TOP_SIM_HEARTBEAT_EN
    assign led = {cpu_clk_q, cpu_out[8:0]};
`else
    assign led = cpu_out[9:0];
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Wider address builds keep only the low two decimal digits.
    assign pc_mod  = 7'(cpu_pc % 100);
    assign sp_mod  = 7'(cpu_sp % 100);
    assign pc_tens = 4'(pc_mod / 7'd10);
    assign pc_ones = 4'(pc_mod % 7'd10);
    assign sp_tens = 4'(sp_mod / 7'd10);
    assign sp_ones = 4'(sp_mod % 7'd10);

    assign hex = {seg7(sp_tens), seg7(sp_ones), seg7(pc_tens), seg7(pc_ones)};
endmodule

// File: tb/tb_top_sim.sv
// -----------------------------------------------------------------------------
// tb_top_sim -- bench for top_sim. Keeps an instruction-level model of the
// boot program and compares LEDs and 7-segment digits at every instruction
// boundary, with randomised switch values.
// -----------------------------------------------------------------------------
module tb_top_sim;
    localparam int DIV = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  btn   = '0;
    logic [8:0]  sw    = '0;
    logic [9:0]  led;
    logic [27:0] hex;

    int n_checks = 0;
    int n_fail   = 0;

    top_sim #(.DIVISOR(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .sw    (sw),
        .led   (led),
        .hex   (hex)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0]  seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};
    logic [15:0] m_mem [64];
    int          m_pc, m_sp;
    logic [15:0] m_acc, m_out;

    function automatic logic [27:0] exp_hex(input int pc, input int sp);
        return {seg_tbl[(sp % 100) / 10], seg_tbl[sp % 10],
                seg_tbl[(pc % 100) / 10], seg_tbl[pc % 10]};
    endfunction

    function automatic logic [9:0] exp_led(input logic [15:0] o);
`ifdef TOP_SIM_HEARTBEAT_EN
        return {1'b1, o[8:0]};   // sampled just after a cpu_clk rise
`else
        return o[9:0];
`endif
    endfunction

    task automatic model_load();
        for (int i = 0; i < 64; i++) m_mem[i] = 16'h0000;
        m_mem[0]  = {4'h7, 12'd16};
        m_mem[8]  = {4'h1, 12'd40};
        m_mem[9]  = {4'h4, 12'd0};
        m_mem[10] = {4'h3, 12'd0};
        m_mem[11] = {4'h4, 12'd0};
        m_mem[12] = {4'h3, 12'd0};
        m_mem[13] = {4'h4, 12'd0};
        m_mem[14] = {4'h2, 12'd40};
        m_mem[15] = {4'h7, 12'd60};
        m_mem[16] = {4'h7, 12'd16};
        m_mem[60] = {4'h7, 12'd63};
        m_mem[63] = {4'h5, 12'd0};
    endtask

    task automatic model_reset();
        m_pc = 8; m_sp = 63; m_acc = '0; m_out = '0;
    endtask

    task automatic model_step(input logic [8:0] swv);
        logic [15:0] w;
        int          a;
        w    = m_mem[m_pc];
        a    = int'(w[5:0]);
        m_pc = (m_pc + 1) % 64;
        case (w[15:12])
            4'h1: m_acc = m_mem[a];
            4'h2: m_mem[a] = m_acc;
            4'h3: m_acc = {7'd0, swv};
            4'h4: m_out = m_acc;
            4'h5: begin m_mem[m_sp] = m_acc; m_sp = (m_sp + 63) % 64; end
            4'h6: begin m_sp = (m_sp + 1) % 64; m_acc = m_mem[m_sp]; end
            4'h7: m_pc = a;
            default: ;
        endcase
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit clk_seen_high;
        clk_seen_high = 0;
        sw = 9'h000;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clks(1);
            if (dut.cpu_clk_q !== 1'b0) clk_seen_high = 1;
        end
        n_checks++;
        if (clk_seen_high) begin n_fail++; $display("FAIL reset_cpu_clk: toggled during reset, required stay 0"); end
        n_checks++;
        if (led !== 10'h000) begin n_fail++; $display("FAIL reset_led: got %h want 000", led); end
        n_checks++;
        if (hex[13:7] !== 7'b1000000) begin n_fail++; $display("FAIL reset_pc_tens: got %b want 1000000", hex[13:7]); end
        n_checks++;
        if (hex[6:0] !== 7'b0000000) begin n_fail++; $display("FAIL reset_pc_ones: got %b want 0000000", hex[6:0]); end
        n_checks++;
        if (hex[27:21] !== 7'b0000010) begin n_fail++; $display("FAIL reset_sp_tens: got %b want 0000010", hex[27:21]); end
        n_checks++;
        if (hex[20:14] !== 7'b0110000) begin n_fail++; $display("FAIL reset_sp_ones: got %b want 0110000", hex[20:14]); end
    endtask

    // cpu_clk after k clk rises is (k/DIV) mod 2; PC moves only on its rises.
    task automatic test_divider();
        int          r, epc;
        logic        eclk;
        logic [27:0] eh;
        rst_n = 1'b0;
        for (int k = 1; k <= 6 * DIV; k++) begin
            clks(1);
            eclk = 1'((k / DIV) % 2);
            r    = (k + DIV) / (2 * DIV);
            epc  = 8 + (r + 1) / 2;
            eh   = exp_hex(epc, 63);
            n_checks++;
            if (dut.cpu_clk_q !== eclk) begin
                n_fail++; $display("FAIL div_cpu_clk k=%0d: got %b want %b", k, dut.cpu_clk_q, eclk);
            end
            n_checks++;
            if (hex !== eh) begin
                n_fail++; $display("FAIL div_pc k=%0d: got %h want %h", k, hex, eh);
            end
        end
        rst_n = 1'b1;
        model_reset();
        clks(3);
    endtask

    task automatic test_program(input int pass);
        logic [8:0]  swv;
        logic [27:0] eh;
        rst_n = 1'b0;
        for (int i = 0; i < 14; i++) begin
            sw = 9'($urandom);
            clks(i == 0 ? DIV : 2 * DIV);          // just after fetch edge
            swv = 9'($urandom);
            if (pass == 0 && i == 2) swv = 9'h008;
            if (pass == 0 && i == 4) swv = 9'h009;
            sw = swv;                              // value the IN will see
            clks(2 * DIV);                         // just after execute edge
            model_step(swv);
            eh = exp_hex(m_pc, m_sp);
            n_checks++;
            if (led !== exp_led(m_out)) begin
                n_fail++; $display("FAIL prog_led p%0d i%0d: got %h want %h", pass, i, led, exp_led(m_out));
            end
            n_checks++;
            if (hex !== eh) begin
                n_fail++; $display("FAIL prog_hex p%0d i%0d: got %h want %h", pass, i, hex, eh);
            end
            if (m_pc == 10) begin
                n_checks++;
                if (hex[13:0] !== {7'b1111001, 7'b1000000}) begin
                    n_fail++; $display("FAIL pc10_digits: got %b", hex[13:0]);
                end
            end
            if (m_sp == 62) begin
                n_checks++;
                if (hex[27:14] !== {7'b0000010, 7'b0100100}) begin
                    n_fail++; $display("FAIL sp62_digits: got %b", hex[27:14]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        clks($urandom_range(0, 2 * DIV - 1));
        #2 rst_n = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (hex !== exp_hex(8, 63)) begin n_fail++; $display("FAIL midrst_hex: got %h want %h", hex, exp_hex(8, 63)); end
        n_checks++;
        if (led !== 10'h000) begin n_fail++; $display("FAIL midrst_led: got %h want 000", led); end
        n_checks++;
        if (dut.cpu_clk_q !== 1'b0 || dut.div_cnt_q !== '0) begin
            n_fail++; $display("FAIL midrst_div: cpu_clk %b cnt %0d want 0 0", dut.cpu_clk_q, dut.div_cnt_q);
        end
        clks(2);
    endtask

    initial begin
        model_load();
        model_reset();
        #1;
        test_reset();
        test_divider();
        for (int p = 0; p < 3; p++) begin
            test_program(p);
            test_midreset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
